// File: rtl/spio_link_burst_arbiter.sv
// spio_link_burst_arbiter
//   Shares one rdy/vld packet link between two packet sources. Ownership is
//   round-robin with a bounded burst: the owner may send up to MAX_BURST
//   back-to-back packets while the other source waits, then yields. The
//   output is a single register stage, and throughput is one packet per cycle.
//
// Parameters
//   PKT_BITS   packet width in bits
//   MAX_BURST  max consecutive packets per owner while the other waits (>=1)
//
// Ports
//   CLK_IN     single clock
//   RESET_IN   synchronous, active-low reset
//   DATA0_IN   source 0 packet        VLD0_IN source 0 valid  RDY0_OUT source 0 ready
//   DATA1_IN   source 1 packet        VLD1_IN source 1 valid  RDY1_OUT source 1 ready
//   DATA_OUT   arbitrated packet      VLD_OUT output valid    RDY_IN   downstream ready
//   GRANT_OUT  source of the packet currently held in DATA_OUT
module spio_link_burst_arbiter #(
  parameter int PKT_BITS  = 72,
  parameter int MAX_BURST = 4
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [PKT_BITS-1:0] DATA0_IN,
  input  logic                VLD0_IN,
  output logic                RDY0_OUT,
  input  logic [PKT_BITS-1:0] DATA1_IN,
  input  logic                VLD1_IN,
  output logic                RDY1_OUT,
  output logic [PKT_BITS-1:0] DATA_OUT,
  output logic                VLD_OUT,
  input  logic                RDY_IN,
  output logic                GRANT_OUT
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;

  logic [PKT_BITS-1:0]   r_data_p0;
  logic                  r_vld_p0;
  logic                  r_grant_p0;

  logic                  w_own;
  logic                  w_own_vld;
  logic                  w_oth_vld;
  logic                  w_out_free;
  logic                  w_sel_any;
  logic                  w_sel_src;
  logic                  w_accept;
  logic [PKT_BITS-1:0]   w_sel_data;

  assign w_own      = (r_state == OWN1);
  assign w_own_vld  = w_own ? VLD1_IN : VLD0_IN;
  assign w_oth_vld  = w_own ? VLD0_IN : VLD1_IN;
  // A stalled output blocks both sources; a draining one can be refilled
  // on the same edge.
  assign w_out_free = !r_vld_p0 || RDY_IN;
  assign w_sel_data = w_sel_src ? DATA1_IN : DATA0_IN;

  // Selection and ownership update. The owner keeps priority until its burst
  // count reaches the limit; past the limit it still wins if the other source
  // is idle, and restarts its count at 1 in that case.
  always_comb begin
    w_sel_any   = 1'b0;
    w_sel_src   = w_own;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    RDY0_OUT    = 1'b0;
    RDY1_OUT    = 1'b0;

    if (w_own_vld && (r_cnt < MAXC)) begin
      w_sel_any = 1'b1;
      w_sel_src = w_own;
    end else if (w_oth_vld) begin
      w_sel_any = 1'b1;
      w_sel_src = !w_own;
    end else if (w_own_vld) begin
      w_sel_any = 1'b1;
      w_sel_src = w_own;
    end

    w_accept = w_out_free && w_sel_any;
    RDY0_OUT = w_accept && !w_sel_src;
    RDY1_OUT = w_accept &&  w_sel_src;

    if (w_accept) begin
      if (w_sel_src == w_own) begin
        w_cnt_nxt = (r_cnt < MAXC) ? r_cnt + ONE : ONE;
      end else begin
        w_state_nxt = w_sel_src ? OWN1 : OWN0;
        w_cnt_nxt   = ONE;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      r_state <= OWN0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- output register stage (p0) ----
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      r_data_p0  <= '0;
      r_vld_p0   <= 1'b0;
      r_grant_p0 <= 1'b0;
    end else if (w_accept) begin
      r_data_p0  <= w_sel_data;
      r_vld_p0   <= 1'b1;
      r_grant_p0 <= w_sel_src;
    end else if (r_vld_p0 && RDY_IN) begin
      r_vld_p0   <= 1'b0;
    end
  end

  assign DATA_OUT  = r_data_p0;
  assign VLD_OUT   = r_vld_p0;
  assign GRANT_OUT = r_grant_p0;

endmodule
